// File: rtl/accum_pkg.sv
// Shared types and constants for the accumulator write sequencer and its skew line.
package accum_pkg;

    localparam int DEFAULT_SYS_COL    = 16;
    localparam int DEFAULT_ACCUM_ROW  = 256;
    localparam int DEFAULT_ADDR_WIDTH = $clog2(DEFAULT_ACCUM_ROW);

    // One write slot travelling down the skew line; en is the MSB.
    typedef struct packed {
        logic                          en;
        logic                          acc;
        logic [DEFAULT_ADDR_WIDTH-1:0] addr;
    } wr_slot_t;

    localparam int WR_SLOT_W = $bits(wr_slot_t);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

    // Number of registered stages needed so the last column taps the last stage.
    function automatic int skew_depth(input int sys_col, input int col_skew);
        return (sys_col - 1) * col_skew + 1;
    endfunction

endpackage

// File: rtl/accum_skew_line.sv
// Stallable delay line of write slots with one tap per column, COL_SKEW stages apart.
module accum_skew_line
    import accum_pkg::*;
#(
    parameter int SYS_COL  = DEFAULT_SYS_COL,
    parameter int COL_SKEW = 1,
    parameter int SLOT_W   = WR_SLOT_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              hold,
    input  logic [SLOT_W-1:0] slot_in,
    output logic [SLOT_W-1:0] tap_out [0:SYS_COL-1]
);

    localparam int DEPTH = skew_depth(SYS_COL, COL_SKEW);

    logic [SLOT_W-1:0] stage_q [0:DEPTH-1];

    // Shift one stage per unheld cycle; the whole line freezes while hold is high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < DEPTH; s++) begin
                stage_q[s] <= '0;
            end
        end else if (!hold) begin
            stage_q[0] <= slot_in;
            for (int s = 1; s < DEPTH; s++) begin
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    for (genvar c = 0; c < SYS_COL; c++) begin : g_tap
        assign tap_out[c] = stage_q[c*COL_SKEW];
    end

endmodule

// File: rtl/accum_wr_seq.sv
// Burst write sequencer: accepts a row burst command, generates wrapped row
// addresses and fans them out to the accumulator columns through a skew line.
//
// Handshake: a command transfers on a rising edge where cmd_valid and cmd_ready
// are both 1; cmd_ready is 1 only in IDLE and does not depend on cmd_valid.
module accum_wr_seq
    import accum_pkg::*;
#(
    parameter  int SYS_COL    = DEFAULT_SYS_COL,
    parameter  int ACCUM_ROW  = DEFAULT_ACCUM_ROW,
    parameter  int MAX_LEN    = 256,
    parameter  int COL_SKEW   = 1,
    localparam int ADDR_WIDTH = $clog2(ACCUM_ROW),
    localparam int LEN_WIDTH  = $clog2(MAX_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_base,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  cmd_acc,
    input  logic                  stall,
    output logic [SYS_COL-1:0]    wr_en_out,
    output logic [SYS_COL-1:0]    wr_acc_out,
    output logic [ADDR_WIDTH-1:0] wr_addr_out [0:SYS_COL-1],
    output logic                  busy,
    output logic                  done
);

    typedef struct packed {
        logic                  en;
        logic                  acc;
        logic [ADDR_WIDTH-1:0] addr;
    } slot_t;

    localparam int SLOT_W  = $bits(slot_t);
    localparam int DEPTH   = skew_depth(SYS_COL, COL_SKEW);
    localparam int DRAIN_W = $clog2(DEPTH + 1);

    localparam logic [DRAIN_W-1:0]  DRAIN_LAST = DRAIN_W'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] ROW_LIMIT  = (ADDR_WIDTH + 1)'(ACCUM_ROW);

    seq_state_t state_q, state_d;

    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  row_idx_q;
    logic                  acc_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DRAIN_W-1:0]    drain_cnt_q;
    logic                  done_q;

    logic                  accept;
    logic                  start;
    logic                  inject;
    logic                  done_d;
    logic [ADDR_WIDTH:0]   base_ext;
    logic [ADDR_WIDTH:0]   addr_inc;
    logic [ADDR_WIDTH-1:0] base_fold;
    logic [ADDR_WIDTH-1:0] addr_next;
    slot_t                 slot_in;
    logic [SLOT_W-1:0]     taps [0:SYS_COL-1];

    // Wrap addresses by compare-and-subtract so non-power-of-2 row counts work.
    always_comb begin
        base_ext  = {1'b0, cmd_base};
        base_fold = cmd_base;
        if (base_ext >= ROW_LIMIT) begin
            base_fold = ADDR_WIDTH'(base_ext - ROW_LIMIT);
        end
        addr_inc  = {1'b0, addr_q} + (ADDR_WIDTH + 1)'(1);
        addr_next = ADDR_WIDTH'(addr_inc);
        if (addr_inc >= ROW_LIMIT) begin
            addr_next = ADDR_WIDTH'(addr_inc - ROW_LIMIT);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        accept    = 1'b0;
        start     = 1'b0;
        inject    = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept = 1'b1;
                    if (cmd_len != '0) begin
                        start   = 1'b1;
                        state_d = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (!stall) begin
                    inject = 1'b1;
                    if (row_idx_q == len_q - LEN_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!stall && (drain_cnt_q == DRAIN_LAST)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Burst registers: latch the command, then step row index and address per injection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            len_q     <= '0;
            row_idx_q <= '0;
            acc_q     <= 1'b0;
            addr_q    <= '0;
        end else if (start) begin
            len_q     <= cmd_len;
            row_idx_q <= '0;
            acc_q     <= cmd_acc;
            addr_q    <= base_fold;
        end else if (inject) begin
            row_idx_q <= row_idx_q + LEN_WIDTH'(1);
            addr_q    <= addr_next;
        end
    end

    // Drain counter advances only on unstalled DRAIN cycles, so stalls stretch DRAIN.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drain_cnt_q <= '0;
        end else if (state_q != DRAIN) begin
            drain_cnt_q <= '0;
        end else if (!stall) begin
            drain_cnt_q <= drain_cnt_q + DRAIN_W'(1);
        end
    end

    // Completion pulse, registered so it appears the cycle after the deciding edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    // Slot offered to stage 0; empty slots carry zero address and mode.
    always_comb begin
        slot_in = '0;
        if (inject) begin
            slot_in.en   = 1'b1;
            slot_in.acc  = acc_q;
            slot_in.addr = addr_q;
        end
    end

    accum_skew_line #(
        .SYS_COL  (SYS_COL),
        .COL_SKEW (COL_SKEW),
        .SLOT_W   (SLOT_W)
    ) u_skew_line (
        .clk     (clk),
        .rstn    (rstn),
        .hold    (stall),
        .slot_in (slot_in),
        .tap_out (taps)
    );

    // Write enables are masked during stall so a held slot is written only once.
    for (genvar c = 0; c < SYS_COL; c++) begin : g_col
        slot_t tap_s;
        assign tap_s          = taps[c];
        assign wr_en_out[c]   = tap_s.en & ~stall;
        assign wr_acc_out[c]  = tap_s.acc;
        assign wr_addr_out[c] = tap_s.addr;
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;

    // Burst lengths above MAX_LEN are outside the supported command range.
    assert property (@(posedge clk) disable iff (!rstn)
        (cmd_valid && cmd_ready) |-> (cmd_len <= LEN_WIDTH'(MAX_LEN)));

endmodule

// File: tb/tb_accum_wr_seq.sv
// Directed bench for accum_wr_seq: three instances cover the default shape,
// a non-power-of-2 row count and a wider column skew.
module tb_accum_wr_seq;

    localparam int AW = 8;
    localparam int LW = 9;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    int   total = 0;
    int   bad   = 0;

    // clock / reset
    always #5 clk = ~clk;

    // instance a: defaults
    logic          a_valid, a_ready, a_acc_in, a_stall, a_busy, a_done;
    logic [AW-1:0] a_base;
    logic [LW-1:0] a_len;
    logic [15:0]   a_wr_en, a_wr_acc;
    logic [AW-1:0] a_wr_addr [0:15];

    accum_wr_seq dut_a (
        .clk(clk), .rstn(rstn), .cmd_valid(a_valid), .cmd_ready(a_ready),
        .cmd_base(a_base), .cmd_len(a_len), .cmd_acc(a_acc_in), .stall(a_stall),
        .wr_en_out(a_wr_en), .wr_acc_out(a_wr_acc), .wr_addr_out(a_wr_addr),
        .busy(a_busy), .done(a_done)
    );

    // instance b: ACCUM_ROW = 200
    logic          b_valid, b_ready, b_acc_in, b_stall, b_busy, b_done;
    logic [AW-1:0] b_base;
    logic [LW-1:0] b_len;
    logic [15:0]   b_wr_en, b_wr_acc;
    logic [AW-1:0] b_wr_addr [0:15];

    accum_wr_seq #(.ACCUM_ROW(200)) dut_b (
        .clk(clk), .rstn(rstn), .cmd_valid(b_valid), .cmd_ready(b_ready),
        .cmd_base(b_base), .cmd_len(b_len), .cmd_acc(b_acc_in), .stall(b_stall),
        .wr_en_out(b_wr_en), .wr_acc_out(b_wr_acc), .wr_addr_out(b_wr_addr),
        .busy(b_busy), .done(b_done)
    );

    // instance c: SYS_COL = 4, COL_SKEW = 3
    logic          c_valid, c_ready, c_acc_in, c_stall, c_busy, c_done;
    logic [AW-1:0] c_base;
    logic [LW-1:0] c_len;
    logic [3:0]    c_wr_en, c_wr_acc;
    logic [AW-1:0] c_wr_addr [0:3];

    accum_wr_seq #(.SYS_COL(4), .COL_SKEW(3)) dut_c (
        .clk(clk), .rstn(rstn), .cmd_valid(c_valid), .cmd_ready(c_ready),
        .cmd_base(c_base), .cmd_len(c_len), .cmd_acc(c_acc_in), .stall(c_stall),
        .wr_en_out(c_wr_en), .wr_acc_out(c_wr_acc), .wr_addr_out(c_wr_addr),
        .busy(c_busy), .done(c_done)
    );

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [AW-1:0] base, input logic [LW-1:0] len, input logic acc);
        a_base = base; a_len = len; a_acc_in = acc; a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
    endtask

    task automatic send_b(input logic [AW-1:0] base, input logic [LW-1:0] len, input logic acc);
        b_base = base; b_len = len; b_acc_in = acc; b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
    endtask

    task automatic send_c(input logic [AW-1:0] base, input logic [LW-1:0] len, input logic acc);
        c_base = base; c_len = len; c_acc_in = acc; c_valid = 1'b1;
        tick();
        c_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [AW-1:0] addr_or;
        #1 rstn = 1'b0;
        #2;
        addr_or = '0;
        for (int c = 0; c < 16; c++) addr_or = addr_or | a_wr_addr[c];
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_a got=%b want=1", a_ready); end
        total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL reset_busy_a got=%b want=0", a_busy); end
        total++; if (a_done !== 1'b0) begin bad++; $display("FAIL reset_done_a got=%b want=0", a_done); end
        total++; if (a_wr_en !== 16'h0) begin bad++; $display("FAIL reset_en_a got=%h want=0", a_wr_en); end
        total++; if (a_wr_acc !== 16'h0) begin bad++; $display("FAIL reset_acc_a got=%h want=0", a_wr_acc); end
        total++; if (addr_or !== 8'h0) begin bad++; $display("FAIL reset_addr_a got=%h want=0", addr_or); end
        total++; if (b_ready !== 1'b1 || b_busy !== 1'b0 || b_wr_en !== 16'h0) begin
            bad++; $display("FAIL reset_b got ready=%b busy=%b en=%h want 1/0/0", b_ready, b_busy, b_wr_en);
        end
        total++; if (c_ready !== 1'b1 || c_busy !== 1'b0 || c_wr_en !== 4'h0) begin
            bad++; $display("FAIL reset_c got ready=%b busy=%b en=%h want 1/0/0", c_ready, c_busy, c_wr_en);
        end
        tick();
        tick();
        rstn = 1'b1;
        tick();
    endtask

    // base=10 len=3 acc=1: col c writes row i at T+2+i+c, busy T+1..T+19, done T+20
    task automatic test_burst();
        logic [15:0] exp_en;
        logic        exp_busy;
        int          row;
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL burst_ready_pre got=%b want=1", a_ready); end
        send_a(8'd10, 9'd3, 1'b1);
        for (int k = 1; k <= 22; k++) begin
            exp_en = '0;
            for (int c = 0; c < 16; c++) begin
                row = k - 2 - c;
                if (row >= 0 && row < 3) exp_en[c] = 1'b1;
            end
            total++; if (a_wr_en !== exp_en) begin bad++; $display("FAIL burst_en k=%0d got=%h want=%h", k, a_wr_en, exp_en); end
            for (int c = 0; c < 16; c++) begin
                row = k - 2 - c;
                if (exp_en[c]) begin
                    total++;
                    if (a_wr_addr[c] !== 8'(10 + row) || a_wr_acc[c] !== 1'b1) begin
                        bad++; $display("FAIL burst_addr k=%0d col=%0d got=%0d/%b want=%0d/1", k, c, a_wr_addr[c], a_wr_acc[c], 10 + row);
                    end
                end
            end
            exp_busy = (k <= 19);
            total++; if (a_busy !== exp_busy) begin bad++; $display("FAIL burst_busy k=%0d got=%b want=%b", k, a_busy, exp_busy); end
            total++; if (a_ready !== !exp_busy) begin bad++; $display("FAIL burst_ready k=%0d got=%b want=%b", k, a_ready, !exp_busy); end
            total++; if (a_done !== (k == 20)) begin bad++; $display("FAIL burst_done k=%0d got=%b want=%b", k, a_done, (k == 20)); end
            tick();
        end
    endtask

    // ACCUM_ROW=200, base=198 len=4: every column writes 198,199,0,1; done T+21
    task automatic test_wrap();
        logic [AW-1:0] rows [0:3];
        logic [15:0]   exp_en;
        int            row;
        rows[0] = 8'd198; rows[1] = 8'd199; rows[2] = 8'd0; rows[3] = 8'd1;
        send_b(8'd198, 9'd4, 1'b0);
        for (int k = 1; k <= 23; k++) begin
            exp_en = '0;
            for (int c = 0; c < 16; c++) begin
                row = k - 2 - c;
                if (row >= 0 && row < 4) exp_en[c] = 1'b1;
            end
            total++; if (b_wr_en !== exp_en) begin bad++; $display("FAIL wrap_en k=%0d got=%h want=%h", k, b_wr_en, exp_en); end
            for (int c = 0; c < 16; c++) begin
                row = k - 2 - c;
                if (exp_en[c]) begin
                    total++;
                    if (b_wr_addr[c] !== rows[row] || b_wr_acc[c] !== 1'b0) begin
                        bad++; $display("FAIL wrap_addr k=%0d col=%0d got=%0d/%b want=%0d/0", k, c, b_wr_addr[c], b_wr_acc[c], rows[row]);
                    end
                end
            end
            total++; if (b_busy !== (k <= 20)) begin bad++; $display("FAIL wrap_busy k=%0d got=%b want=%b", k, b_busy, (k <= 20)); end
            total++; if (b_done !== (k == 21)) begin bad++; $display("FAIL wrap_done k=%0d got=%b want=%b", k, b_done, (k == 21)); end
            tick();
        end
    endtask

    // SYS_COL=4 COL_SKEW=3 len=1: writes at T+2,5,8,11; done T+12
    task automatic test_skew();
        logic [3:0] exp_en;
        send_c(8'd7, 9'd1, 1'b1);
        for (int k = 1; k <= 14; k++) begin
            exp_en = '0;
            for (int c = 0; c < 4; c++) begin
                if (k == 2 + 3 * c) exp_en[c] = 1'b1;
            end
            total++; if (c_wr_en !== exp_en) begin bad++; $display("FAIL skew_en k=%0d got=%h want=%h", k, c_wr_en, exp_en); end
            for (int c = 0; c < 4; c++) begin
                if (exp_en[c]) begin
                    total++;
                    if (c_wr_addr[c] !== 8'd7 || c_wr_acc[c] !== 1'b1) begin
                        bad++; $display("FAIL skew_addr k=%0d col=%0d got=%0d/%b want=7/1", k, c, c_wr_addr[c], c_wr_acc[c]);
                    end
                end
            end
            total++; if (c_busy !== (k <= 11)) begin bad++; $display("FAIL skew_busy k=%0d got=%b want=%b", k, c_busy, (k <= 11)); end
            total++; if (c_done !== (k == 12)) begin bad++; $display("FAIL skew_done k=%0d got=%b want=%b", k, c_done, (k == 12)); end
            tick();
        end
    endtask

    // base=0 len=4, stall at T+3..T+4: each (col,row) written once, done T+23
    task automatic test_stall();
        int          wr_cnt [0:15][0:3];
        int          u;
        int          row;
        logic [15:0] exp_en;
        for (int c = 0; c < 16; c++) for (int r = 0; r < 4; r++) wr_cnt[c][r] = 0;
        u = 0;
        send_a(8'd0, 9'd4, 1'b0);
        for (int k = 1; k <= 26; k++) begin
            a_stall = (k == 3 || k == 4);
            #1;
            exp_en = '0;
            if (!a_stall) begin
                for (int c = 0; c < 16; c++) begin
                    row = u - 1 - c;
                    if (row >= 0 && row < 4) exp_en[c] = 1'b1;
                end
            end
            total++; if (a_wr_en !== exp_en) begin bad++; $display("FAIL stall_en k=%0d got=%h want=%h", k, a_wr_en, exp_en); end
            for (int c = 0; c < 16; c++) begin
                row = u - 1 - c;
                if (exp_en[c]) begin
                    total++;
                    if (a_wr_addr[c] !== 8'(row) || a_wr_acc[c] !== 1'b0) begin
                        bad++; $display("FAIL stall_addr k=%0d col=%0d got=%0d/%b want=%0d/0", k, c, a_wr_addr[c], a_wr_acc[c], row);
                    end
                end
                if (a_wr_en[c] === 1'b1 && a_wr_addr[c] < 8'd4) wr_cnt[c][a_wr_addr[c]]++;
            end
            total++; if (a_busy !== (k <= 22)) begin bad++; $display("FAIL stall_busy k=%0d got=%b want=%b", k, a_busy, (k <= 22)); end
            total++; if (a_done !== (k == 23)) begin bad++; $display("FAIL stall_done k=%0d got=%b want=%b", k, a_done, (k == 23)); end
            if (!a_stall) u++;
            tick();
        end
        a_stall = 1'b0;
        for (int c = 0; c < 16; c++) begin
            for (int r = 0; r < 4; r++) begin
                total++;
                if (wr_cnt[c][r] != 1) begin bad++; $display("FAIL stall_once col=%0d row=%0d got=%0d want=1", c, r, wr_cnt[c][r]); end
            end
        end
    endtask

    // len=0: no writes, done at T+1, ready stays 1
    task automatic test_zero_len();
        send_a(8'd5, 9'd0, 1'b1);
        total++; if (a_done !== 1'b1) begin bad++; $display("FAIL zero_done got=%b want=1", a_done); end
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL zero_ready got=%b want=1", a_ready); end
        total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL zero_busy got=%b want=0", a_busy); end
        total++; if (a_wr_en !== 16'h0) begin bad++; $display("FAIL zero_en got=%h want=0", a_wr_en); end
        for (int k = 2; k <= 20; k++) begin
            tick();
            total++;
            if (a_wr_en !== 16'h0 || a_done !== 1'b0 || a_ready !== 1'b1) begin
                bad++; $display("FAIL zero_quiet k=%0d got en=%h done=%b ready=%b want 0/0/1", k, a_wr_en, a_done, a_ready);
            end
        end
        tick();
    endtask

    // reset at T+10 (DRAIN) abandons the burst immediately
    task automatic test_reset_mid_drain();
        send_a(8'd10, 9'd3, 1'b1);
        repeat (9) tick();
        total++; if (a_busy !== 1'b1 || a_wr_en === 16'h0) begin
            bad++; $display("FAIL mid_pre got busy=%b en=%h want busy=1 en!=0", a_busy, a_wr_en);
        end
        rstn = 1'b0;
        #1;
        total++; if (a_wr_en !== 16'h0) begin bad++; $display("FAIL mid_en got=%h want=0", a_wr_en); end
        total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", a_busy); end
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b want=1", a_ready); end
        total++; if (a_done !== 1'b0) begin bad++; $display("FAIL mid_done got=%b want=0", a_done); end
        tick();
        rstn = 1'b1;
        for (int k = 0; k < 25; k++) begin
            tick();
            total++;
            if (a_wr_en !== 16'h0 || a_done !== 1'b0 || a_busy !== 1'b0) begin
                bad++; $display("FAIL mid_after k=%0d got en=%h done=%b busy=%b want 0/0/0", k, a_wr_en, a_done, a_busy);
            end
        end
    endtask

    initial begin
        a_valid = 1'b0; a_base = '0; a_len = '0; a_acc_in = 1'b0; a_stall = 1'b0;
        b_valid = 1'b0; b_base = '0; b_len = '0; b_acc_in = 1'b0; b_stall = 1'b0;
        c_valid = 1'b0; c_base = '0; c_len = '0; c_acc_in = 1'b0; c_stall = 1'b0;
        test_reset();
        test_burst();
        test_wrap();
        test_skew();
        test_stall();
        test_zero_len();
        test_reset_mid_drain();
        test_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/accum_wr_seq.md
Name: accum_wr_seq

Overview:
Successor to the single-shot accumulator write skew chain. Accepts a burst write command (base row, length, accumulate/overwrite mode) over a valid/ready handshake. Generates the row address sequence internally and fans it out to SYS_COL accumulator columns through a stallable delay line with configurable per-column skew. Sits between the systolic-array output controller and the accumulator SRAM banks; signals completion when the last column has written the last row.

Parameters:
SYS_COL, 16, number of accumulator columns (one write port each)
ACCUM_ROW, 256, rows per accumulator bank; any value >= 2, need not be a power of 2
MAX_LEN, 256, maximum burst length in rows
COL_SKEW, 1, cycles of delay between adjacent columns (>= 1)
ADDR_WIDTH (localparam), $clog2(ACCUM_ROW), row address width
LEN_WIDTH (localparam), $clog2(MAX_LEN+1), burst length width

Ports:
clk  in  1  clock
rstn  in  1  reset; asynchronous, active-low
cmd_valid  in  1  burst command valid
cmd_ready  out  1  block can accept a command
cmd_base  in  ADDR_WIDTH  first row address
cmd_len  in  LEN_WIDTH  rows in burst; 0 is legal
cmd_acc  in  1  1 = accumulate into row, 0 = overwrite
stall  in  1  array stall; freezes sequencing and delay line
wr_en_out  out  SYS_COL  per-column write enable
wr_acc_out  out  SYS_COL  per-column accumulate mode, valid when matching wr_en_out bit is 1
wr_addr_out  out  ADDR_WIDTH x SYS_COL (unpacked [0:SYS_COL-1])  per-column row address
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on burst completion

Behaviour:
- Reset (rstn low, async): state IDLE, delay line cleared, row/drain counters 0. Outputs: cmd_ready=1, busy=0, done=0, all wr_en_out/wr_acc_out=0, all wr_addr_out=0. Reset mid-burst abandons the burst; no further writes and no done.
- FSM states: IDLE, RUN, DRAIN.
- IDLE: cmd_ready=1. Accept on cmd_valid&&cmd_ready at a rising edge. cmd_len>0: latch base/len/acc, row index=0, go to RUN. cmd_len==0: no writes, done=1 the following cycle, stay in IDLE. cmd_len>MAX_LEN: unsupported; verify with an assertion only.
- RUN: cmd_ready=0. Each cycle with stall=0, injects slot {en=1, acc, addr} into delay-line stage 0 and increments the row index. After injecting row len-1, go to DRAIN. Stall=1 cycles inject nothing and do not advance the row index.
- Address generation: addr_i = (base + i) mod ACCUM_ROW. Use compare-and-subtract, not truncation, so non-power-of-2 ACCUM_ROW wraps correctly.
- Delay line: (SYS_COL-1)*COL_SKEW+1 registered stages of {en, acc, addr}. Column c taps stage c*COL_SKEW. Stage 0 is registered, so column 0 sees row i one cycle after injection.
- Stall: all stages hold while stall=1. wr_en_out is forced to 0 during stall to prevent duplicate writes. wr_addr_out and wr_acc_out hold.
- Unstalled timing, burst accepted at edge T: row i reaches column c in cycle T+2+i+c*COL_SKEW.
- DRAIN: count unstalled cycles until the final slot leaves the column SYS_COL-1 tap. The cycle after the last write is visible, pulse done=1 and go to IDLE. cmd_ready returns to 1 in that same cycle. Every stalled cycle extends DRAIN by one cycle.
- Back-to-back bursts: a new command is accepted only in IDLE. Overlap with a draining burst is not supported in this generation.
- Empty slots (en=0) propagate with addr=0 and acc=0.

Decomposition:
- Package accum_pkg:
  - typedef wr_slot_t (packed struct {en, acc, addr[ADDR_WIDTH]}), parametrised via a localparam width matching ACCUM_ROW defaults.
  - typedef enum seq_state_t {IDLE, RUN, DRAIN}.
  - Shared constant for default SYS_COL/ACCUM_ROW.
- Sub-module accum_skew_line: parametrised stallable delay line of wr_slot_t with SYS_COL taps at COL_SKEW spacing, asynchronously reset. It is reusable by the read-side controller.

Test Plan:
1. Defaults; cmd base=10, len=3, acc=1, no stall; accepted at T -> column 0 writes rows 10,11,12 at T+2..T+4; column 15 writes rows 10,11,12 at T+17..T+19 with wr_acc_out=1; done at T+20; busy T+1..T+19.
2. Wrap with ACCUM_ROW=200: base=198, len=4 -> every column writes addresses 198,199,0,1 in order.
3. COL_SKEW=3, SYS_COL=4, len=1 at T -> column c writes at T+2+3c, i.e. T+2, T+5, T+8, T+11; done at T+12.
4. Stall for 2 cycles mid-RUN (base=0, len=4, stall at T+3..T+4) -> no wr_en_out during stall; each column writes rows 0..3 exactly once; done 2 cycles later than the unstalled case.
5. cmd_len=0 accepted at T -> no wr_en_out ever; done=1 at T+1; cmd_ready stays 1.
6. Assert rstn low mid-DRAIN -> same cycle: all wr_en_out=0, busy=0, cmd_ready=1; no done pulse; next command behaves as scenario 1.
